// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the small types used by the writeback arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Requester index width covers up to four sources.
  localparam int GRANT_W = 2;
  typedef logic [GRANT_W-1:0] grant_idx_t;

  function automatic grant_idx_t rr_next(grant_idx_t idx, int n);
    return (int'(idx) == n - 1) ? '0 : idx + grant_idx_t'(1);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-requester valid/ready request lanes plus the regfile write port.
interface regfile_wb_arbiter_if #(parameter int NUM_REQ = 2);
  // Handshake: a requester raises req_valid[i] with addr/data stable; the write is
  // transferred in the cycle where req_valid[i] & req_ready[i]. req_ready is one-hot or zero.
  logic [NUM_REQ-1:0]                          req_valid;
  logic [NUM_REQ-1:0]                          req_ready;
  logic [NUM_REQ*regfile_pkg::REG_ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*regfile_pkg::REG_DATA_W-1:0]  req_data;
  logic                                        regWrite;
  logic [regfile_pkg::REG_ADDR_W-1:0]          wrAddr;
  logic [regfile_pkg::REG_DATA_W-1:0]          wrData;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, regWrite, wrAddr, wrData
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, regWrite, wrAddr, wrData
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  grant_idx_t   ptr,
  output logic [N-1:0] grant,
  output grant_idx_t   grantIdx
);

  logic found;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    // Outer loop walks priority order; inner loop maps the rotated slot to a constant index.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (i == (int'(ptr) + k) % N) && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grantIdx = grant_idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the regfile write port among NUM_REQ writeback sources,
// with a registered write stage, $zero filter and saturating contention counter.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_hold,
  regfile_wb_arbiter_if.slave    bus,
  output grant_idx_t             grant_id,
  output logic [CNT_W-1:0]       contend_cnt,
  output grant_idx_t             dbgPtr
);

  grant_idx_t              ptr;
  logic [NUM_REQ-1:0]      arbGrant;
  grant_idx_t              arbIdx;
  logic                    xfer;
  logic [REG_ADDR_W-1:0]   selAddr;
  logic [REG_DATA_W-1:0]   selData;
  logic [2:0]              nValid;
  logic                    contend;

  logic                    regWriteQ;
  logic [REG_ADDR_W-1:0]   wrAddrQ;
  logic [REG_DATA_W-1:0]   wrDataQ;
  grant_idx_t              grantIdQ;
  logic [CNT_W-1:0]        cntQ;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

  // No grants while stalled or in the reset cycle; regWrite never feeds back here.
  assign bus.req_ready = (reset || wb_hold) ? '0 : arbGrant;
  assign xfer          = |bus.req_ready;

  always_comb begin
    selAddr = '0;
    selData = '0;
    nValid  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      nValid = nValid + 3'(bus.req_valid[k]);
      if (arbGrant[k]) begin
        selAddr = bus.req_addr[k*REG_ADDR_W +: REG_ADDR_W];
        selData = bus.req_data[k*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  assign contend = (nValid >= 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      regWriteQ <= 1'b0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      grantIdQ  <= '0;
      cntQ      <= '0;
    end else begin
      // Writes to $zero are consumed but never reach the regfile enable.
      regWriteQ <= xfer && (selAddr != ZERO_REG);
      if (xfer) begin
        ptr      <= rr_next(arbIdx, NUM_REQ);
        wrAddrQ  <= selAddr;
        wrDataQ  <= selData;
        grantIdQ <= arbIdx;
      end
      if (contend && (cntQ != '1)) cntQ <= cntQ + CNT_W'(1);
    end
  end

  assign bus.regWrite = regWriteQ;
  assign bus.wrAddr   = wrAddrQ;
  assign bus.wrData   = wrDataQ;
  assign grant_id     = grantIdQ;
  assign contend_cnt  = cntQ;
  assign dbgPtr       = ptr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: a 2-source arbiter with a regfile model, and a 3-source arbiter
// with a 4-bit contention counter.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic reset;
  logic hold2;
  logic hold3;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(2)) bus2 ();
  regfile_wb_arbiter_if #(.NUM_REQ(3)) bus3 ();

  grant_idx_t  gid2, gid3, ptr2, ptr3;
  logic [15:0] cnt2;
  logic [3:0]  cnt3;

  regfile_wb_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .wb_hold(hold2), .bus(bus2.slave),
    .grant_id(gid2), .contend_cnt(cnt2), .dbgPtr(ptr2)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .wb_hold(hold3), .bus(bus3.slave),
    .grant_id(gid3), .contend_cnt(cnt3), .dbgPtr(ptr3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model behind dut2; its own reset wins over a write in the same cycle.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (bus2.regWrite) begin
      rf[bus2.wrAddr] <= bus2.wrData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req2(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    bus2.req_valid[i]        = v;
    bus2.req_addr[i*5 +: 5]  = a;
    bus2.req_data[i*32 +: 32] = d;
  endtask

  initial begin
    reset = 1'b1;
    hold2 = 1'b0;
    hold3 = 1'b0;
    bus2.req_valid = '0; bus2.req_addr = '0; bus2.req_data = '0;
    bus3.req_valid = '0; bus3.req_addr = '0; bus3.req_data = '0;

    // 1. reset with all valids high
    set_req2(0, 1'b1, 5'd3, 32'hA0A0_0003);
    set_req2(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check("rst_ready2", 64'(bus2.req_ready), 64'h0);
    check("rst_ready3", 64'(bus3.req_ready), 64'h0);
    tick();
    check("rst_regWrite", 64'(bus2.regWrite), 64'h0);
    check("rst_wrAddr", 64'(bus2.wrAddr), 64'h0);
    check("rst_wrData", 64'(bus2.wrData), 64'h0);
    check("rst_grant_id", 64'(gid2), 64'h0);
    check("rst_cnt", 64'(cnt2), 64'h0);
    check("rst_ptr", 64'(ptr2), 64'h0);
    reset = 1'b0;
    settle();
    check("t1_ready_req0", 64'(bus2.req_ready), 64'h1);
    tick();
    check("t1_regWrite", 64'(bus2.regWrite), 64'h1);
    check("t1_wrAddr", 64'(bus2.wrAddr), 64'h3);
    check("t1_wrData", 64'(bus2.wrData), 64'hA0A0_0003);
    check("t1_grant_id", 64'(gid2), 64'h0);
    check("t1_cnt", 64'(cnt2), 64'h1);

    // 2. single req1
    set_req2(0, 1'b0, 5'd3, 32'hA0A0_0003);
    settle();
    check("t2_ready_req1", 64'(bus2.req_ready), 64'h2);
    tick();
    check("t2_regWrite", 64'(bus2.regWrite), 64'h1);
    check("t2_wrAddr", 64'(bus2.wrAddr), 64'h5);
    check("t2_wrData", 64'(bus2.wrData), 64'hDEAD_BEEF);
    check("t2_grant_id", 64'(gid2), 64'h1);
    set_req2(1, 1'b0, 5'd5, 32'hDEAD_BEEF);
    settle();
    check("t2_ready_idle", 64'(bus2.req_ready), 64'h0);
    tick();
    check("t2_idle_regWrite", 64'(bus2.regWrite), 64'h0);
    check("t2_idle_wrAddr_hold", 64'(bus2.wrAddr), 64'h5);
    check("t2_idle_wrData_hold", 64'(bus2.wrData), 64'hDEAD_BEEF);
    check("t2_rf5", 64'(rf[5]), 64'hDEAD_BEEF);
    check("t2_rf3", 64'(rf[3]), 64'hA0A0_0003);
    check("t2_cnt", 64'(cnt2), 64'h1);

    // 4. write to $zero is accepted but dropped
    set_req2(0, 1'b1, 5'd0, 32'h0000_1234);
    settle();
    check("t4_ready_req0", 64'(bus2.req_ready), 64'h1);
    tick();
    check("t4_regWrite", 64'(bus2.regWrite), 64'h0);
    check("t4_wrData", 64'(bus2.wrData), 64'h0000_1234);
    set_req2(0, 1'b0, 5'd0, 32'h0000_1234);
    tick();
    check("t4_rf0", 64'(rf[0]), 64'h0);
    check("t4_ptr", 64'(ptr2), 64'h1);

    // 5. hold for three cycles with both requesters valid
    set_req2(0, 1'b1, 5'd9, 32'h0000_0099);
    set_req2(1, 1'b1, 5'd10, 32'h0000_00AA);
    hold2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t5_hold_ready", 64'(bus2.req_ready), 64'h0);
      tick();
      check("t5_hold_regWrite", 64'(bus2.regWrite), 64'h0);
      check("t5_hold_ptr", 64'(ptr2), 64'h1);
    end
    check("t5_hold_cnt", 64'(cnt2), 64'h4);
    hold2 = 1'b0;
    settle();
    check("t5_release_ready", 64'(bus2.req_ready), 64'h2);
    tick();
    check("t5_rel_regWrite", 64'(bus2.regWrite), 64'h1);
    check("t5_rel_wrAddr", 64'(bus2.wrAddr), 64'hA);
    check("t5_rel_grant_id", 64'(gid2), 64'h1);
    check("t5_rel_cnt", 64'(cnt2), 64'h5);
    set_req2(1, 1'b0, 5'd10, 32'h0000_00AA);
    settle();
    check("t5_next_ready", 64'(bus2.req_ready), 64'h1);
    tick();
    check("t5_next_wrAddr", 64'(bus2.wrAddr), 64'h9);
    check("t5_next_wrData", 64'(bus2.wrData), 64'h0000_0099);
    check("t5_next_grant_id", 64'(gid2), 64'h0);
    check("t5_next_cnt", 64'(cnt2), 64'h5);
    set_req2(0, 1'b0, 5'd9, 32'h0000_0099);

    // 3. three sources all valid: rotation 0,1,2,0,1,2
    bus3.req_valid = 3'b111;
    bus3.req_addr  = {5'd3, 5'd2, 5'd1};
    bus3.req_data  = {32'h33, 32'h32, 32'h31};
    for (int c = 0; c < 6; c++) begin
      settle();
      check("t3_ready", 64'(bus3.req_ready), 64'(1 << (c % 3)));
      tick();
      check("t3_regWrite", 64'(bus3.regWrite), 64'h1);
      check("t3_grant_id", 64'(gid3), 64'(c % 3));
      check("t3_wrAddr", 64'(bus3.wrAddr), 64'((c % 3) + 1));
      check("t3_wrData", 64'(bus3.wrData), 64'(32'h31 + (c % 3)));
    end
    check("t3_cnt6", 64'(cnt3), 64'h6);

    // 6. saturation of the 4-bit counter, then reset mid-stream
    for (int c = 6; c < 20; c++) begin
      tick();
      if (c == 14) check("t6_cnt15", 64'(cnt3), 64'hF);
    end
    check("t6_cnt_sat", 64'(cnt3), 64'hF);
    reset = 1'b1;
    settle();
    check("t6_rst_ready", 64'(bus3.req_ready), 64'h0);
    check("t6_rst_regWrite_still", 64'(bus3.regWrite), 64'h1);
    tick();
    check("t6_cnt_cleared", 64'(cnt3), 64'h0);
    check("t6_regWrite_cleared", 64'(bus3.regWrite), 64'h0);
    check("t6_wrAddr_cleared", 64'(bus3.wrAddr), 64'h0);
    check("t6_grant_id_cleared", 64'(gid3), 64'h0);
    check("t6_ptr_cleared", 64'(ptr3), 64'h0);
    check("t6_cnt2_cleared", 64'(cnt2), 64'h0);
    reset = 1'b0;
    bus3.req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
